// File: rtl/triumph_if_stage_pkg.sv
// triumph_if_stage_pkg: shared types, defaults and helpers for the instruction fetch stage
package triumph_if_stage_pkg;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
  localparam int unsigned IF_FIFO_DEPTH = 2;
  typedef enum logic {IF_RUN = 1'b0, IF_WAIT_GNT = 1'b1} if_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/triumph_if_fifo.sv
// triumph_if_fifo: synchronous prefetch FIFO holding {pc, instr} entries with flush
module triumph_if_fifo
  import triumph_if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = IF_FIFO_DEPTH,
  localparam int unsigned W = $bits(if_entry_t),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Entry storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
  // Pointers and occupancy; flush empties the buffer in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
      if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/triumph_if_stage.sv
// triumph_if_stage: fetch PC owner, imem req/gnt/rvalid master and prefetch buffer feeding ID
module triumph_if_stage
  import triumph_if_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  input  logic        id_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  if_state_e state_q, state_d;
  logic en_q;
  logic [31:0] fetch_pc_q, fetch_pc_d, redir_pc_q, redir_pc_d;
  logic redir_pend_q, redir_pend_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic [31:0] pcq_q [FIFO_DEPTH];
  logic [PW-1:0] pcq_wr_q, pcq_rd_q;
  logic [CW-1:0] fifo_count;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop, gnt_ok, room;
  if_entry_t push_entry, head_entry;
  assign gnt_ok = imem_req_o && imem_gnt_i;
  assign fifo_pop = !fifo_empty && id_ready_i;
  assign fifo_push = imem_rvalid_i && discard_q == '0 && !redirect_i;
  assign room = (!fifo_full || fifo_pop) &&
                ({1'b0, outstanding_q} + {1'b0, fifo_count} - (CW + 1)'(fifo_pop) < DEPTH_C);
  assign push_entry = '{pc: pcq_q[pcq_rd_q], instr: imem_rdata_i};
  assign imem_addr_o = fetch_pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_data_o = instr_valid_o ? head_entry.instr : '0;
  assign instr_pc_o = instr_valid_o ? head_entry.pc : '0;
  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IF_RUN;
    else state_q <= state_d;
  end
  // An ungranted request parks in WAIT_GNT; any grant returns to RUN
  always_comb state_d = imem_req_o && !imem_gnt_i ? IF_WAIT_GNT : IF_RUN;
  // Request is held while waiting, otherwise issued whenever a buffer slot is guaranteed
  always_comb imem_req_o = en_q && (state_q == IF_WAIT_GNT || room);
  // Next fetch PC, in-flight accounting and redirect bookkeeping
  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt_ok) - CW'(imem_rvalid_i);
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    redir_pend_d = redir_pend_q;
    discard_d = imem_rvalid_i && discard_q != '0 ? discard_q - CW'(1) : discard_q;
    if (gnt_ok) begin
      fetch_pc_d = redirect_i ? word_align(redirect_pc_i) : redir_pend_q ? redir_pc_q : fetch_pc_q + 32'd4;
      redir_pend_d = 1'b0;
    end else if (redirect_i && imem_req_o) begin
      redir_pend_d = 1'b1;
      redir_pc_d = word_align(redirect_pc_i);
    end else if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
    end
    if (redirect_i) discard_d = outstanding_d + CW'(imem_req_o && !imem_gnt_i);
  end
  // Fetch bookkeeping registers; en_q keeps the request low until the first edge after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      fetch_pc_q <= BOOT_ADDR;
      redir_pc_q <= BOOT_ADDR;
      redir_pend_q <= 1'b0;
      outstanding_q <= '0;
      discard_q <= '0;
    end else begin
      en_q <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
    end
  end
  // Granted addresses, consumed in order as responses return
  always_ff @(posedge clk_i) begin
    if (gnt_ok) pcq_q[pcq_wr_q] <= imem_addr_o;
  end
  // PC queue pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcq_wr_q <= '0;
      pcq_rd_q <= '0;
    end else begin
      if (gnt_ok) pcq_wr_q <= pcq_wr_q == PW'(FIFO_DEPTH - 1) ? '0 : pcq_wr_q + PW'(1);
      if (imem_rvalid_i) pcq_rd_q <= pcq_rd_q == PW'(FIFO_DEPTH - 1) ? '0 : pcq_rd_q + PW'(1);
    end
  end
  triumph_if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_i(redirect_i),
    .push_i(fifo_push),
    .data_i(push_entry),
    .pop_i(fifo_pop),
    .data_o(head_entry),
    .count_o(fifo_count),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
endmodule

// File: doc/triumph_if_stage.md
Name: triumph_if_stage

Overview:
Instruction fetch stage: owns the fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions in a small prefetch FIFO. It feeds the ID stage with instruction word plus PC under a valid/ready handshake. Taken branches/jumps resolved downstream redirect the PC, flush the FIFO and discard in-flight responses.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value after reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, prefetch buffer entries; also the maximum number of outstanding memory requests

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request
imem_addr_o  output  32  word-aligned fetch address
imem_gnt_i  input  1  memory accepted request this cycle
imem_rvalid_i  input  1  read data valid, in-order, at least 1 cycle after gnt
imem_rdata_i  input  32  instruction word
instr_valid_o  output  1  FIFO head valid to ID
instr_data_o  output  32  FIFO head instruction
instr_pc_o  output  32  PC of FIFO head instruction
id_ready_i  input  1  ID consumes head when instr_valid_o && id_ready_i
redirect_i  input  1  taken branch/jump from EX
redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (rst_ni low, async): fetch_pc=BOOT_ADDR, FIFO empty, outstanding=0, discard=0; imem_req_o=0, imem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_data_o=0, instr_pc_o=0. Reset mid-transaction drops everything; responses after deassert that belong to pre-reset requests are not guarded (memory is reset together).
- FSM states: RUN, WAIT_GNT. RUN: imem_req_o=1 when (outstanding + fifo_count) < FIFO_DEPTH; if !gnt go WAIT_GNT. WAIT_GNT: imem_req_o held 1, imem_addr_o held stable until gnt; return to RUN on gnt.
- On gnt: outstanding+1, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0). Address of each granted request pushed to an internal PC queue (depth FIFO_DEPTH) paired with its response.
- On rvalid: outstanding-1; if discard>0 then discard-1 and data dropped, else {pc,rdata} pushed to FIFO. Push cannot overflow (issue rule guarantees a slot).
- First-fetch latency: req at cycle 0 with gnt, rvalid at cycle 1 -> instr_valid_o=1 in cycle 2. Push and pop in same cycle allowed; full FIFO with pop permits a new request that cycle.
- Outputs instr_* driven from registered FIFO head; stable while instr_valid_o && !id_ready_i.
- Redirect (highest priority): FIFO flushed; discard <= outstanding after this cycle's gnt/rvalid accounting (a gnt in the redirect cycle counts as outstanding and will be discarded, an rvalid in the redirect cycle is dropped). fetch_pc <= {redirect_pc_i[31:2],2'b00}. instr_valid_o=0 the next cycle; a pop coincident with redirect is still the consumed instruction. In WAIT_GNT, pending request is not withdrawn: address held until gnt, its response discarded, then new PC issued.
- No new request while discard>0 would exceed FIFO_DEPTH outstanding; discarded responses count against outstanding until returned.

Decomposition:
- triumph_riscv_defines.v: add `BOOT_ADDR_DEFAULT, `IF_FIFO_DEPTH, FSM state encodings `IF_RUN/`IF_WAIT_GNT.
- Sub-module triumph_if_fifo: parameterised synchronous FIFO (push/pop/flush, count, full/empty, 64-bit {pc,instr} payload), instantiated once.

Test Plan:
- Reset release, memory gnt same cycle, rvalid next cycle, rdata=PC^32'hA5A5_A5A5, id_ready_i=1 -> instr_pc_o sequence 0x0,0x4,0x8… one per cycle, instr_data_o matching.
- id_ready_i=0 for 5 cycles -> at most 2 entries buffered, imem_req_o drops to 0, head held at PC 0x0; ready high -> 0x0,0x4 drained in order, fetch resumes at 0x8.
- imem_gnt_i withheld 3 cycles at addr 0x10 -> imem_req_o=1 and imem_addr_o=0x10 constant throughout; granted on cycle 4.
- Redirect to 0x200 with 2 responses outstanding -> both responses dropped, next instr_pc_o=0x200, no instruction from 0x8/0xC reaches ID.
- Redirect to 0x1003 during WAIT_GNT at 0x40 -> 0x40 issued on gnt and discarded, next request addr 0x1000, instr_pc_o=0x1000.
- BOOT_ADDR=32'hFFFF_FFF8 -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
